// File: rtl/kamikaze_ahb_pkg.sv
// kamikaze_ahb_pkg: shared AHB-Lite encodings for the kamikaze arbiter
package kamikaze_ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;
endpackage

// File: rtl/kamikaze_ahb_arb_grant.sv
// kamikaze_ahb_arb_grant: M1-priority grant with a saturating counter that forces M0 in
// after STARVE_LIMIT consecutive accepted M1 wins.
module kamikaze_ahb_arb_grant #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0,
  input  logic req1,
  input  logic s_HREADY,
  output logic gnt0,
  output logic gnt1
);
  logic [CNT_W-1:0] starve_q, starve_d;
  always_comb begin
    gnt0     = req0 & (!req1 | (starve_q == CNT_W'(STARVE_LIMIT)));
    gnt1     = req1 & !gnt0;
    starve_d = !s_HREADY ? starve_q :
               (!req0 | gnt0) ? '0 :
               (gnt1 && starve_q != '1) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) starve_q <= '0;
    else        starve_q <= starve_d;
endmodule

// File: rtl/kamikaze_ahb_arbiter.sv
// kamikaze_ahb_arbiter: two-master AHB-Lite arbiter (M0 fetch, M1 load/store) onto one
// slave port, with address-phase grant muxing and data-phase routing by owner.
module kamikaze_ahb_arbiter
  import kamikaze_ahb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_HADDR,
  input  logic [1:0]  m0_HTRANS,
  input  logic        m0_HWRITE,
  input  logic [2:0]  m0_HSIZE,
  input  logic [3:0]  m0_HPROT,
  input  logic [31:0] m0_HWDATA,
  output logic [31:0] m0_HRDATA,
  output logic        m0_HREADY,
  output logic        m0_HRESP,
  input  logic [31:0] m1_HADDR,
  input  logic [1:0]  m1_HTRANS,
  input  logic        m1_HWRITE,
  input  logic [2:0]  m1_HSIZE,
  input  logic [3:0]  m1_HPROT,
  input  logic [31:0] m1_HWDATA,
  output logic [31:0] m1_HRDATA,
  output logic        m1_HREADY,
  output logic        m1_HRESP,
  output logic [31:0] s_HADDR,
  output logic [1:0]  s_HTRANS,
  output logic        s_HWRITE,
  output logic [2:0]  s_HSIZE,
  output logic [3:0]  s_HPROT,
  output logic [2:0]  s_HBURST,
  output logic        s_HMASTLOCK,
  output logic [31:0] s_HWDATA,
  input  logic [31:0] s_HRDATA,
  input  logic        s_HREADY,
  input  logic        s_HRESP
);
  logic   req0, req1, gnt0, gnt1;
  owner_e owner_q, owner_d;
  // Requests are masked in reset so no grant, and hence no slave transfer, can leak out.
  assign req0 = rst_i & m0_HTRANS[1];
  assign req1 = rst_i & m1_HTRANS[1];
  kamikaze_ahb_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_grant (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req0     (req0),
    .req1     (req1),
    .s_HREADY (s_HREADY),
    .gnt0     (gnt0),
    .gnt1     (gnt1)
  );
  always_comb begin
    owner_d     = !s_HREADY ? owner_q : gnt0 ? OWN_M0 : gnt1 ? OWN_M1 : OWN_NONE;
    s_HADDR     = gnt1 ? m1_HADDR  : m0_HADDR;
    s_HTRANS    = gnt0 ? m0_HTRANS : gnt1 ? m1_HTRANS : HTRANS_IDLE;
    s_HWRITE    = gnt0 ? m0_HWRITE : gnt1 & m1_HWRITE;
    s_HSIZE     = gnt1 ? m1_HSIZE  : m0_HSIZE;
    s_HPROT     = gnt1 ? m1_HPROT  : m0_HPROT;
    s_HBURST    = 3'b000;
    s_HMASTLOCK = 1'b0;
    s_HWDATA    = owner_q == OWN_M0 ? m0_HWDATA : owner_q == OWN_M1 ? m1_HWDATA : '0;
    m0_HRDATA   = s_HRDATA;
    m1_HRDATA   = s_HRDATA;
    m0_HRESP    = (owner_q == OWN_M0) & s_HRESP;
    m1_HRESP    = (owner_q == OWN_M1) & s_HRESP;
    m0_HREADY   = !rst_i | (s_HREADY & (!req0 | gnt0));
    m1_HREADY   = !rst_i | (s_HREADY & (!req1 | gnt1));
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
endmodule

// File: tb/tb_kamikaze_ahb_arbiter.sv
// tb_kamikaze_ahb_arbiter: directed and random stimulus; a reference model pushes expected
// slave/master outputs into a queue that a negedge monitor pops and compares.
module tb_kamikaze_ahb_arbiter;
  import kamikaze_ahb_pkg::*;
  localparam int LIMIT = 4;
  localparam int CMAX  = 7;
  logic clk_i = 0, rst_i = 0;
  logic [31:0] m0_HADDR = 0, m1_HADDR = 0, m0_HWDATA = 0, m1_HWDATA = 0, s_HRDATA = 0;
  logic [1:0]  m0_HTRANS = 0, m1_HTRANS = 0;
  logic        m0_HWRITE = 0, m1_HWRITE = 0, s_HREADY = 1, s_HRESP = 0;
  logic [2:0]  m0_HSIZE = 0, m1_HSIZE = 0;
  logic [3:0]  m0_HPROT = 0, m1_HPROT = 0;
  logic [31:0] m0_HRDATA, m1_HRDATA, s_HADDR, s_HWDATA;
  logic        m0_HREADY, m1_HREADY, m0_HRESP, m1_HRESP, s_HWRITE, s_HMASTLOCK;
  logic [1:0]  s_HTRANS;
  logic [2:0]  s_HSIZE, s_HBURST;
  logic [3:0]  s_HPROT;
  int tests = 0, fails = 0;

  kamikaze_ahb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_HADDR(m0_HADDR), .m0_HTRANS(m0_HTRANS), .m0_HWRITE(m0_HWRITE), .m0_HSIZE(m0_HSIZE),
    .m0_HPROT(m0_HPROT), .m0_HWDATA(m0_HWDATA), .m0_HRDATA(m0_HRDATA), .m0_HREADY(m0_HREADY),
    .m0_HRESP(m0_HRESP),
    .m1_HADDR(m1_HADDR), .m1_HTRANS(m1_HTRANS), .m1_HWRITE(m1_HWRITE), .m1_HSIZE(m1_HSIZE),
    .m1_HPROT(m1_HPROT), .m1_HWDATA(m1_HWDATA), .m1_HRDATA(m1_HRDATA), .m1_HREADY(m1_HREADY),
    .m1_HRESP(m1_HRESP),
    .s_HADDR(s_HADDR), .s_HTRANS(s_HTRANS), .s_HWRITE(s_HWRITE), .s_HSIZE(s_HSIZE),
    .s_HPROT(s_HPROT), .s_HBURST(s_HBURST), .s_HMASTLOCK(s_HMASTLOCK), .s_HWDATA(s_HWDATA),
    .s_HRDATA(s_HRDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          win;
    logic [31:0] haddr, hwdata, rdata;
    logic [1:0]  htrans;
    logic        hwrite, r0, r1, e0, e1;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
  } exp_t;
  exp_t q[$];

  // Reference state: who owns the data phase (0 none, 1 M0, 2 M1) and how many accepted
  // M1 wins M0 has sat through.
  int own = 0, cnt = 0;

  function automatic int winner();
    bit a = rst_i && m0_HTRANS[1];
    bit b = rst_i && m1_HTRANS[1];
    if (a && b) return (cnt == LIMIT) ? 1 : 2;
    return a ? 1 : b ? 2 : 0;
  endfunction

  task automatic step(input logic rst, input logic [1:0] t0, input logic [31:0] a0,
                      input logic w0, input logic [31:0] wd0, input logic [1:0] t1,
                      input logic [31:0] a1, input logic w1, input logic [31:0] wd1,
                      input logic srdy, input logic sresp, input logic [31:0] rd);
    int w;
    exp_t e;
    @(posedge clk_i);
    #2;
    w = winner();
    if (!rst_i) begin own = 0; cnt = 0; end
    else if (s_HREADY) begin
      own = w;
      if (!m0_HTRANS[1] || w == 1) cnt = 0;
      else if (w == 2 && cnt < CMAX) cnt++;
    end
    rst_i = rst; m0_HTRANS = t0; m0_HADDR = a0; m0_HWRITE = w0; m0_HWDATA = wd0;
    m1_HTRANS = t1; m1_HADDR = a1; m1_HWRITE = w1; m1_HWDATA = wd1;
    s_HREADY = srdy; s_HRESP = sresp; s_HRDATA = rd;
    m0_HSIZE = 3'($urandom); m1_HSIZE = 3'($urandom);
    m0_HPROT = 4'($urandom); m1_HPROT = 4'($urandom);
    if (!rst_i) begin own = 0; cnt = 0; end
    w = winner();
    e.win    = w;
    e.haddr  = (w == 2) ? m1_HADDR : m0_HADDR;
    e.htrans = (w == 1) ? m0_HTRANS : (w == 2) ? m1_HTRANS : HTRANS_IDLE;
    e.hwrite = (w == 1) ? m0_HWRITE : (w == 2) ? m1_HWRITE : 1'b0;
    e.hsize  = (w == 2) ? m1_HSIZE : m0_HSIZE;
    e.hprot  = (w == 2) ? m1_HPROT : m0_HPROT;
    e.hwdata = (own == 1) ? m0_HWDATA : (own == 2) ? m1_HWDATA : 32'h0;
    e.rdata  = s_HRDATA;
    e.e0     = (own == 1) && s_HRESP;
    e.e1     = (own == 2) && s_HRESP;
    e.r0     = !rst_i || (s_HREADY && (!m0_HTRANS[1] || w == 1));
    e.r1     = !rst_i || (s_HREADY && (!m1_HTRANS[1] || w == 2));
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("s_HADDR", s_HADDR, e.haddr);
      chk("s_HTRANS", 32'(s_HTRANS), 32'(e.htrans));
      chk("s_HWRITE", 32'(s_HWRITE), 32'(e.hwrite));
      if (e.win != 0) begin
        chk("s_HSIZE", 32'(s_HSIZE), 32'(e.hsize));
        chk("s_HPROT", 32'(s_HPROT), 32'(e.hprot));
      end
      chk("s_HWDATA", s_HWDATA, e.hwdata);
      chk("m0_HRDATA", m0_HRDATA, e.rdata);
      chk("m1_HRDATA", m1_HRDATA, e.rdata);
      chk("m0_HREADY", 32'(m0_HREADY), 32'(e.r0));
      chk("m1_HREADY", 32'(m1_HREADY), 32'(e.r1));
      chk("m0_HRESP", 32'(m0_HRESP), 32'(e.e0));
      chk("m1_HRESP", 32'(m1_HRESP), 32'(e.e1));
      chk("s_HBURST", 32'(s_HBURST), 32'h0);
      chk("s_HMASTLOCK", 32'(s_HMASTLOCK), 32'h0);
    end
  end

  initial begin
    // reset
    repeat (2) step(0, 2'b10, 32'h40, 0, 0, 2'b10, 32'h80, 0, 0, 0, 1, 0);
    // fetch alone
    step(1, 2'b10, 32'h100, 0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h13);
    step(1, 2'b10, 32'h104, 0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h13);
    step(1, 2'b00, 32'h108, 0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h13);
    // contention: M1 write wins, M0 read follows while M1's data goes out
    step(1, 2'b10, 32'h200, 0, 0, 2'b10, 32'h8000, 1, 32'hDEADBEEF, 1, 0, 0);
    step(1, 2'b10, 32'h200, 0, 0, 2'b00, 32'h8000, 0, 32'hDEADBEEF, 1, 0, 0);
    step(1, 2'b00, 32'h200, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    // starvation: both request continuously
    for (int i = 0; i < 12; i++)
      step(1, 2'b10, 32'h300, 0, 0, 2'b11, 32'h9000 + 32'(4 * i), 1, 32'(i), 1, 0, 32'(i));
    step(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    // wait states during an M1 data phase while M0 requests
    step(1, 2'b10, 32'h400, 0, 0, 2'b10, 32'hA000, 1, 32'h11, 1, 0, 0);
    step(1, 2'b10, 32'h400, 0, 0, 2'b10, 32'hA004, 1, 32'h22, 0, 0, 0);
    step(1, 2'b10, 32'h400, 0, 0, 2'b10, 32'hA004, 1, 32'h22, 0, 0, 0);
    step(1, 2'b10, 32'h400, 0, 0, 2'b10, 32'hA004, 1, 32'h22, 1, 0, 0);
    step(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    // two-cycle error response on an M0 data phase, M1 requesting meanwhile
    step(1, 2'b10, 32'h500, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    step(1, 2'b00, 32'h504, 0, 0, 2'b10, 32'hB000, 0, 0, 0, 1, 0);
    step(1, 2'b00, 32'h504, 0, 0, 2'b10, 32'hB000, 0, 0, 1, 1, 0);
    step(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    // reset mid M1 data phase, asserted between clock edges
    step(1, 2'b00, 0, 0, 0, 2'b10, 32'hC000, 1, 0, 1, 0, 0);
    step(0, 2'b10, 32'h600, 0, 0, 2'b10, 32'hC004, 1, 32'h55, 0, 1, 0);
    step(1, 2'b00, 0, 0, 0, 2'b10, 32'hC008, 1, 32'h66, 1, 1, 0);
    step(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 32'h77, 1, 1, 0);
    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) != 0, 2'($urandom), $urandom, 1'($urandom), $urandom,
           2'($urandom), $urandom, 1'($urandom), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom);
    @(negedge clk_i);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 expected", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
